// File: rtl/serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator
//
// Multi-cycle magnitude comparator. Compares two WIDTH-bit operands DIGIT bits
// per clock, most significant digit first, and stops at the first differing
// digit. Optional two's-complement interpretation.
//
// Handshake: a request is accepted on a rising clk edge where start=1 and
// busy=0; operands and signed_mode are captured on that edge only. busy stays
// high until the completing edge, where eq/lt/gt update and done pulses for
// one cycle. start while busy=1 is dropped (not queued). start may already be
// high in the done cycle, giving back-to-back compares with no idle cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        compare request
//   x, y         operands A and B (WIDTH bits)
//   signed_mode  1 = two's-complement compare, 0 = unsigned
//   busy         compare in progress
//   done         one-cycle pulse when eq/lt/gt update
//   eq, lt, gt   result of the last completed compare (one-hot after first)
// -----------------------------------------------------------------------------
module serial_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IW-1:0]    LAST_IDX  = IW'(N - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] xa, xa_n;
  logic [WIDTH-1:0] ya, ya_n;
  logic             done_n, eq_n, lt_n, gt_n;

  // The latched operands are shifted left one digit per cycle, so the digit
  // under compare is always the top DIGIT bits.
  logic [DIGIT-1:0] xd, yd;
  assign xd = xa[WIDTH-1 -: DIGIT];
  assign yd = ya[WIDTH-1 -: DIGIT];

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      xa    <= '0;
      ya    <= '0;
      done  <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      xa    <= xa_n;
      ya    <= ya_n;
      done  <= done_n;
      eq    <= eq_n;
      lt    <= lt_n;
      gt    <= gt_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    xa_n    = xa;
    ya_n    = ya;
    done_n  = 1'b0;
    eq_n    = eq;
    lt_n    = lt;
    gt_n    = gt;

    case (state)
      IDLE: begin
        if (start) begin
          // Flipping the sign bit of both operands at capture maps two's
          // complement order onto unsigned order; only digit 0 is affected.
          xa_n    = signed_mode ? (x ^ SIGN_MASK) : x;
          ya_n    = signed_mode ? (y ^ SIGN_MASK) : y;
          idx_n   = '0;
          state_n = RUN;
        end
      end

      RUN: begin
        if (xd != yd) begin
          eq_n    = 1'b0;
          lt_n    = (xd < yd);
          gt_n    = (xd > yd);
          done_n  = 1'b1;
          idx_n   = '0;
          state_n = IDLE;
        end else if (idx == LAST_IDX) begin
          eq_n    = 1'b1;
          lt_n    = 1'b0;
          gt_n    = 1'b0;
          done_n  = 1'b1;
          idx_n   = '0;
          state_n = IDLE;
        end else begin
          idx_n = idx + IW'(1);
          xa_n  = xa << DIGIT;
          ya_n  = ya << DIGIT;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
